dn_route_ctrl: RTL and testbench

//  Configuration and sequencing controller for a distribution-network (DN) fabric of 2x2 dn_router switches.

---
 rtl/dn_route_ctrl.sv | 134 +++++++++++++
 tb/tb_dn_route_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/dn_route_ctrl.sv
// Configuration and sequencing controller for a DN fabric of 2x2 routers:
// loads one route word per stage, strobes set_en, then opens route_en for N beats.
module dn_route_ctrl #(
    parameter int NUM_PORTS  = 8,
    parameter int NUM_STAGES = 5,
    parameter int CNT_W      = 16
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    input  logic                             abort,
    input  logic [CNT_W-1:0]                 num_beats,
    input  logic                             cfg_valid,
    output logic                             cfg_ready,
    input  logic [NUM_PORTS-1:0]             cfg_data,
    input  logic                             in_valid,
    output logic                             in_ready,
    output logic                             set_en,
    output logic                             route_en,
    output logic [NUM_STAGES*NUM_PORTS-1:0]  route_signal,
    output logic                             busy,
    output logic                             done
);

    localparam int unsigned STG_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
    localparam logic [STG_W-1:0] LAST_STAGE = STG_W'(NUM_STAGES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SET,
        S_ROUTE,
        S_DONE
    } state_e;

    state_e                                  state_q, state_d;
    logic [STG_W-1:0]                        stage_cnt_q, stage_cnt_d;
    logic [CNT_W-1:0]                        beat_cnt_q, beat_cnt_d;
    logic [CNT_W-1:0]                        nbeats_q, nbeats_d;
    logic [NUM_STAGES-1:0][NUM_PORTS-1:0]    shadow_q;
    logic                                    cfg_accept;
    logic                                    cfg_ready_q, set_en_q, route_en_q;
    logic                                    busy_q, done_q;

    always_comb begin
        state_d     = state_q;
        stage_cnt_d = stage_cnt_q;
        beat_cnt_d  = beat_cnt_q;
        nbeats_d    = nbeats_q;
        cfg_accept  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_LOAD;
                    nbeats_d    = num_beats;
                    stage_cnt_d = '0;
                end
            end
            S_LOAD: begin
                if (cfg_valid) begin
                    cfg_accept  = 1'b1;
                    stage_cnt_d = stage_cnt_q + STG_W'(1);
                    if (stage_cnt_q == LAST_STAGE) begin
                        state_d = S_SET;
                    end
                end
            end
            S_SET: begin
                beat_cnt_d = '0;
                state_d    = (nbeats_q == '0) ? S_DONE : S_ROUTE;
            end
            S_ROUTE: begin
                if (in_valid) begin
                    beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    if (beat_cnt_q == nbeats_q - CNT_W'(1)) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Abort cancels every side effect of this cycle, including a start seen in IDLE.
        if (abort) begin
            state_d     = S_IDLE;
            stage_cnt_d = stage_cnt_q;
            beat_cnt_d  = beat_cnt_q;
            nbeats_d    = nbeats_q;
            cfg_accept  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            stage_cnt_q <= '0;
            beat_cnt_q  <= '0;
            nbeats_q    <= '0;
            shadow_q    <= '0;
            cfg_ready_q <= 1'b0;
            set_en_q    <= 1'b0;
            route_en_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            stage_cnt_q <= stage_cnt_d;
            beat_cnt_q  <= beat_cnt_d;
            nbeats_q    <= nbeats_d;
            if (cfg_accept) begin
                for (int unsigned s = 0; s < NUM_STAGES; s++) begin
                    if (stage_cnt_q == STG_W'(s)) begin
                        shadow_q[s] <= cfg_data;
                    end
                end
            end
            // Outputs are decoded from the next state so they are flops aligned with state_q.
            cfg_ready_q <= (state_d == S_LOAD);
            set_en_q    <= (state_d == S_SET);
            route_en_q  <= (state_d == S_ROUTE);
            busy_q      <= (state_d != S_IDLE);
            done_q      <= (state_d == S_DONE);
        end
    end

    assign cfg_ready    = cfg_ready_q;
    assign set_en       = set_en_q;
    assign route_en     = route_en_q;
    assign in_ready     = route_en_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign route_signal = shadow_q;

endmodule

// File: tb/tb_dn_route_ctrl.sv
// Directed bench for dn_route_ctrl: config words and beat counts are queued as they are
// driven and checked when set_en / done appear.
module tb_dn_route_ctrl;

    localparam int NP = 8;
    localparam int NS = 5;
    localparam int CW = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              start, abort;
    logic [CW-1:0]     num_beats;
    logic              cfg_valid, cfg_ready;
    logic [NP-1:0]     cfg_data;
    logic              in_valid, in_ready;
    logic              set_en, route_en;
    logic [NS*NP-1:0]  route_signal;
    logic              busy, done;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0]        cfg_exp[$];
    int                beats_exp[$];
    int                job_beats = 0;
    int                route_cyc = 0;
    int                done_seen = 0;
    logic [NS*NP-1:0]  exp_rs;
    logic [NS*NP-1:0]  last_rs;
    int                done_before;

    dn_route_ctrl #(.NUM_PORTS(NP), .NUM_STAGES(NS), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .num_beats(num_beats),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_data(cfg_data),
        .in_valid(in_valid), .in_ready(in_ready), .set_en(set_en), .route_en(route_en),
        .route_signal(route_signal), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cfg(input logic [7:0] w, input int gap);
        for (int i = 0; i < gap; i++) begin
            cfg_valid = 1'b0;
            step();
        end
        cfg_valid = 1'b1;
        cfg_data  = w;
        cfg_exp.push_back(w);
        last_rs   = {w, last_rs[NS*NP-1:8]};
        step();
        cfg_valid = 1'b0;
    endtask

    task automatic start_job(input int nb);
        num_beats = CW'(nb);
        start     = 1'b1;
        step();
        start     = 1'b0;
        chk("cfg_ready one cycle after start", cfg_ready, 1);
        chk("busy after start", busy, 1);
    endtask

    task automatic run_beats(input int stall, input int max_cyc);
        for (int i = 0; i < max_cyc; i++) begin
            if (done) break;
            in_valid = (stall != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
            step();
        end
        in_valid = 1'b0;
        chk("done reached within bound", done, 1);
        chk("route_en low in DONE", route_en, 0);
    endtask

    // Scoreboard side: compare queued expectations when the DUT strobes set_en / done.
    always @(negedge clk) begin
        if (!reset) begin
            if (set_en) begin
                chk("cfg words queued at set_en", cfg_exp.size(), NS);
                exp_rs = '0;
                for (int i = 0; i < NS; i++) begin
                    if (cfg_exp.size() > 0) exp_rs[i*8 +: 8] = cfg_exp.pop_front();
                end
                chk("route_signal at set_en", route_signal, exp_rs);
                chk("set_en/route_en overlap", route_en, 0);
                job_beats = 0;
                route_cyc = 0;
            end
            if (route_en) route_cyc++;
            if (route_en && in_valid) job_beats++;
            if (done) begin
                done_seen++;
                chk("beats per job", job_beats, (beats_exp.size() > 0) ? beats_exp.pop_front() : -1);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global timeout: observed no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0; num_beats = '0;
        cfg_valid = 1'b0; cfg_data = '0; in_valid = 1'b0;
        last_rs = '0;
        step(); step();
        chk("reset route_signal", route_signal, 0);
        chk("reset outputs", {cfg_ready, in_ready, set_en, route_en, busy, done}, 0);
        reset = 1'b0;
        step();
        chk("idle busy", busy, 0);

        // Full job, back-to-back config, 3 beats
        beats_exp.push_back(3);
        start_job(3);
        send_cfg(8'h11, 0); send_cfg(8'h22, 0); send_cfg(8'h33, 0);
        send_cfg(8'h44, 0); send_cfg(8'h55, 0);
        chk("set_en one cycle after last cfg", set_en, 1);
        chk("cfg_ready low in SET", cfg_ready, 0);
        in_valid = 1'b1;
        step();
        chk("route_en one cycle after set_en", route_en, 1);
        chk("set_en single cycle", set_en, 0);
        chk("in_ready follows route_en", in_ready, 1);
        step(); step(); step();
        in_valid = 1'b0;
        chk("done after third beat", done, 1);
        chk("route_en dropped", route_en, 0);
        chk("route_signal full word", route_signal, 40'h5544332211);
        step();
        chk("done single cycle", done, 0);
        chk("idle after done", busy, 0);
        chk("shadow retained", route_signal, 40'h5544332211);

        // Stalls on both handshakes
        beats_exp.push_back(3);
        start_job(3);
        send_cfg(8'hA1, 1); send_cfg(8'hB2, 0); send_cfg(8'hC3, 2);
        send_cfg(8'hD4, 1); send_cfg(8'hE5, 3);
        run_beats(1, 200);
        step();
        chk("stall job route_signal", route_signal, 40'hE5D4C3B2A1);

        // Zero beats: SET straight to DONE
        beats_exp.push_back(0);
        start_job(0);
        for (int i = 0; i < NS; i++) send_cfg(8'(8'h60 + i), 0);
        chk("zero beats set_en", set_en, 1);
        step();
        chk("zero beats done after SET", done, 1);
        chk("zero beats route_en", route_en, 0);
        step();

        // Abort during LOAD after two words
        done_before = done_seen;
        start_job(2);
        send_cfg(8'hAA, 0); send_cfg(8'hBB, 0);
        abort = 1'b1;
        step();
        abort = 1'b0;
        cfg_exp.delete();
        chk("abort returns idle", busy, 0);
        chk("abort cfg_ready", cfg_ready, 0);
        chk("abort partial shadow", route_signal, {24'h646362, 16'hBBAA});
        step(); step();
        chk("no done after abort", done_seen, done_before);
        start = 1'b1; abort = 1'b1;
        step();
        start = 1'b0; abort = 1'b0;
        chk("abort beats start in IDLE", busy, 0);

        // Start while busy is ignored; next job overwrites all stages
        beats_exp.push_back(2);
        start_job(2);
        send_cfg(8'h01, 0);
        num_beats = CW'(7); start = 1'b1;
        step();
        start = 1'b0;
        send_cfg(8'h02, 0); send_cfg(8'h03, 0); send_cfg(8'h04, 0); send_cfg(8'h05, 0);
        run_beats(0, 50);
        step();
        chk("overwrite route_signal", route_signal, 40'h0504030201);

        // Asynchronous reset in ROUTE
        done_before = done_seen;
        beats_exp.push_back(9);
        start_job(9);
        for (int i = 0; i < NS; i++) send_cfg(8'(8'h70 + i), 0);
        in_valid = 1'b1;
        step(); step(); step();
        chk("in ROUTE before reset", route_en, 1);
        #2 reset = 1'b1;
        #1;
        chk("async reset route_signal", route_signal, 0);
        chk("async reset outputs", {cfg_ready, in_ready, set_en, route_en, busy, done}, 0);
        in_valid = 1'b0;
        beats_exp.delete();
        @(negedge clk);
        reset = 1'b0;
        step();
        chk("idle after reset release", busy, 0);
        chk("no done on reset abort", done_seen, done_before);

        // Maximum beat count for CNT_W=4
        done_before = done_seen;
        beats_exp.push_back(15);
        start_job(15);
        for (int i = 0; i < NS; i++) send_cfg(8'(8'h80 + i), 0);
        run_beats(0, 100);
        chk("max count route_en cycles", route_cyc, 15);
        step(); step();
        chk("max count done once", done_seen - done_before, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
